// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg : shared state encoding and sizing helper for serial_subtractor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int nchunk(input int n, input int w);
    return n / w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if : operand/result bus with START/BUSY/DONE handshake.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_subtractor_if #(
  parameter int N = 32
);
  logic         EN;
  logic         START;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] DIFF;
  logic         B_OUT;
  logic         OVF;
  logic         ZERO;

  modport master (
    output EN, START, A, B,
    input  BUSY, DONE, DIFF, B_OUT, OVF, ZERO
  );

  modport slave (
    input  EN, START, A, B,
    output BUSY, DONE, DIFF, B_OUT, OVF, ZERO
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor_chunk.sv
// ---------------------------------------------------------------------------
// chunk_subtractor : combinational W-bit A - B - BIN with borrow out.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chunk_subtractor #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         BIN,
  output logic [W-1:0] D,
  output logic         BOUT
);

  logic [W:0] w_res;

  // A negative W+1-bit difference always sets bit W, which is the borrow.
  assign w_res = {1'b0, A} - {1'b0, B} - {{W{1'b0}}, BIN};
  assign D     = w_res[W-1:0];
  assign BOUT  = w_res[W];

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor : chunk-serial N-bit DIFF = A - B, W bits per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
  import sub_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic          CLOCK,
  input  logic          RST,
  serial_subtractor_if.slave bus
);

  localparam int            NCHUNK = nchunk(N, W);
  localparam int            KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (N % W != 0) begin : g_bad_cfg
    $error("serial_subtractor: N (%0d) must be a multiple of W (%0d)", N, W);
  end

  sub_state_t    state_q;
  logic [KW-1:0] k_q;
  logic [N-1:0]  a_q, b_q, acc_q, diff_q;
  logic          borrow_q, bout_q, ovf_q, zero_q;
  logic [N-1:0]  acc_d;
  logic [W-1:0]  chunk_d;
  logic          chunk_bout;

  chunk_subtractor #(.W(W)) u_chunk (
    .A    (a_q[k_q*W +: W]),
    .B    (b_q[k_q*W +: W]),
    .BIN  (borrow_q),
    .D    (chunk_d),
    .BOUT (chunk_bout)
  );

  // On the last chunk acc_d is the complete difference, so flags use it directly.
  always_comb begin
    acc_d = acc_q;
    acc_d[k_q*W +: W] = chunk_d;
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (bus.EN) begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.START) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= 1'b0;
            k_q      <= '0;
            state_q  <= BUSY;
          end else begin
            state_q  <= IDLE;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          borrow_q <= chunk_bout;
          k_q      <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            diff_q  <= acc_d;
            bout_q  <= chunk_bout;
            ovf_q   <= (a_q[N-1] != b_q[N-1]) && (acc_d[N-1] != a_q[N-1]);
            zero_q  <= (acc_d == '0);
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSY  = (state_q == BUSY);
  assign bus.DONE  = (state_q == DONE);
  assign bus.DIFF  = diff_q;
  assign bus.B_OUT = bout_q;
  assign bus.OVF   = ovf_q;
  assign bus.ZERO  = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor : directed and randomized self-checking bench.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int N   = 32;
  localparam int W   = 8;
  localparam int LAT = N / W;

  logic CLOCK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLOCK = ~CLOCK;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N), .W(W)) dut (
    .CLOCK (CLOCK),
    .RST   (RST),
    .bus   (bus)
  );

  // Result packed as {DIFF, B_OUT, OVF, ZERO}, from plain integer arithmetic.
  function automatic logic [N+2:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b);
    longint       ua, ub, sa, sb, sd, smax, smin;
    logic [N-1:0] d;
    logic         bo, ov;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sd   = sa - sb;
    smax = (64'sd1 <<< (N - 1)) - 1;
    smin = -(64'sd1 <<< (N - 1));
    d    = N'(ua - ub);
    bo   = (ua < ub);
    ov   = (sd > smax) || (sd < smin);
    return {d, bo, ov, (d == '0)};
  endfunction

  function automatic logic [N+2:0] observed();
    return {bus.DIFF, bus.B_OUT, bus.OVF, bus.ZERO};
  endfunction

  // Call at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.A     = a;
    bus.B     = b;
    bus.EN    = 1'b1;
    bus.START = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit busy_ok, output bit stable_ok);
    logic [N+2:0] snap;
    snap      = observed();
    cyc       = 0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (bus.DONE !== 1'b1 && cyc < 50) begin
      if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) busy_ok = 1'b0;
      if (observed() !== snap) stable_ok = 1'b0;
      @(negedge CLOCK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    bus.EN    = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge CLOCK);
    checks++;
    if ({bus.BUSY, bus.DONE, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b out=%h, expected all zero",
               bus.BUSY, bus.DONE, observed());
    end
    RST = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, expected 0/0", bus.BUSY, bus.DONE);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [3] = '{32'h01B30FFF, 32'h00000000, 32'h80000000};
    logic [N-1:0] tb [3] = '{32'h00000FFF, 32'h00000001, 32'h00000001};
    logic [N+2:0] te [3] = '{{32'h01B30000, 3'b000}, {32'hFFFFFFFF, 3'b100}, {32'h7FFFFFFF, 3'b010}};
    int cyc; bit bok, sok;
    for (int i = 0; i < 3; i++) begin
      launch(ta[i], tb[i]);
      wait_done(cyc, bok, sok);
      checks++;
      if (cyc !== LAT || !bok || !sok) begin
        errors++;
        $display("FAIL directed%0d_timing: got latency=%0d busy_ok=%0b stable_ok=%0b, expected %0d/1/1",
                 i, cyc, bok, sok, LAT);
      end
      checks++;
      if (observed() !== te[i]) begin
        errors++;
        $display("FAIL directed%0d_result: got %h, expected %h", i, observed(), te[i]);
      end
      @(negedge CLOCK);
      checks++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || observed() !== te[i]) begin
        errors++;
        $display("FAIL directed%0d_done_pulse: got done=%0b busy=%0b out=%h, expected 0/0/%h",
                 i, bus.DONE, bus.BUSY, observed(), te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok, sok;
    launch(32'hFFA5FFFF, 32'hFFA5FFFF);
    wait_done(cyc, bok, sok);
    checks++;
    if (cyc !== LAT || observed() !== {32'h00000000, 3'b001}) begin
      errors++;
      $display("FAIL b2b_first: got latency=%0d out=%h, expected %0d/%h",
               cyc, observed(), LAT, {32'h00000000, 3'b001});
    end
    launch(32'd5, 32'd3);
    wait_done(cyc, bok, sok);
    checks++;
    if (cyc !== LAT || !bok || !sok || observed() !== {32'h00000002, 3'b000}) begin
      errors++;
      $display("FAIL b2b_second: got latency=%0d busy_ok=%0b stable_ok=%0b out=%h, expected %0d/1/1/%h",
               cyc, bok, sok, observed(), LAT, {32'h00000002, 3'b000});
    end
    @(negedge CLOCK);
  endtask

  task automatic test_stall();
    int cyc; bit bok, sok;
    logic [N+2:0] exp;
    exp = {32'h020D1000, 3'b100};
    launch(32'h01B30FFF, 32'hFFA5FFFF);
    repeat (2) @(negedge CLOCK);
    bus.EN = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: got busy=%0b done=%0b, expected 1/0", bus.BUSY, bus.DONE);
    end
    @(negedge CLOCK);
    bus.EN    = 1'b1;
    bus.START = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    wait_done(cyc, bok, sok);
    checks++;
    if (cyc + 5 !== LAT + 2 || !bok || !sok) begin
      errors++;
      $display("FAIL stall_latency: got latency=%0d busy_ok=%0b stable_ok=%0b, expected %0d/1/1",
               cyc + 5, bok, sok, LAT + 2);
    end
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL stall_result: got %h, expected %h", observed(), exp);
    end
    bus.EN = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (bus.DONE !== 1'b1) begin
      errors++;
      $display("FAIL done_held_stall: got done=%0b, expected 1", bus.DONE);
    end
    bus.EN = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL stray_start_ignored: got done=%0b busy=%0b, expected 0/0", bus.DONE, bus.BUSY);
    end
  endtask

  task automatic test_random();
    int cyc; bit bok, sok;
    logic [N-1:0] a, b;
    logic [N+2:0] exp;
    for (int i = 0; i < 16; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 4) == 0) ? a : $urandom();
      exp = ref_result(a, b);
      launch(a, b);
      wait_done(cyc, bok, sok);
      checks++;
      if (cyc !== LAT || !bok || !sok || observed() !== exp) begin
        errors++;
        $display("FAIL random%0d a=%h b=%h: got latency=%0d busy_ok=%0b stable_ok=%0b out=%h, expected %0d/1/1/%h",
                 i, a, b, cyc, bok, sok, observed(), LAT, exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge CLOCK);
    end
  endtask

  task automatic test_async_reset();
    int cyc; bit bok, sok;
    bit saw_done;
    logic [N-1:0] a, b;
    launch(32'h00000000, 32'h00000001);
    wait_done(cyc, bok, sok);
    @(negedge CLOCK);
    launch(32'h12345678, 32'h11111111);
    repeat (2) @(negedge CLOCK);
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({bus.BUSY, bus.DONE, observed()} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%0b done=%0b out=%h, expected all zero",
               bus.BUSY, bus.DONE, observed());
    end
    @(negedge CLOCK);
    RST = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge CLOCK);
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL aborted_op_activity: got busy/done after reset, expected none");
    end
    a = $urandom();
    b = $urandom();
    launch(a, b);
    wait_done(cyc, bok, sok);
    checks++;
    if (cyc !== LAT || observed() !== ref_result(a, b)) begin
      errors++;
      $display("FAIL post_reset_op: got latency=%0d out=%h, expected %0d/%h",
               cyc, observed(), LAT, ref_result(a, b));
    end
    @(negedge CLOCK);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
